corelet_seq: RTL

- Weight-stationary tile sequencer for the corelet.
- Per start, loops over len_kij kernel positions; each pass loads row weights via L0 into the MAC array, streams len_nij activations, then drains OFIFO results into psum SRAM.
- Drives the corelet 35-bit inst bus and the activation/psum SRAM controls.
- Sits between the top-level testbench/host and the corelet.

---
 rtl/corelet_seq.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/corelet_seq.sv
// corelet_seq: weight-stationary tile sequencer for the corelet.
//
// On each accepted start the sequencer runs one pass per kernel position,
// kij = 0..len_kij-1. Each pass has five steps:
//   1. Read row weight words from SRAM into L0.
//   2. Push those weights into the MAC array.
//   3. Read len_nij activation words into L0.
//   4. Stream the activations through the array (execute).
//   5. Drain OFIFO results into psum SRAM at addresses 0..len_nij-1.
// On every pass after the first, the SFP accumulates into what is already
// there.
//
// Ports:
//   clk          clock
//   reset        asynchronous reset, active low
//   start        one-cycle start pulse; ignored unless idle
//   l0_full      L0 cannot accept a write
//   l0_ready     L0 holds a row vector that can be read
//   ofifo_valid  OFIFO holds a complete col-wide result word
//   inst         35-bit corelet instruction bus
//                  [0]  mac load
//                  [1]  mac execute
//                  [2]  l0_wr
//                  [3]  l0_rd
//                  [6]  ofifo_rd
//                  [33] sfp accumulate
//                  all other bits are 0
//   xmem_cen     activation/weight SRAM chip enable (active low)
//   xmem_addr    activation/weight SRAM read address
//   pmem_wen     psum SRAM write enable (active low)
//   pmem_addr    psum SRAM write address
//   kij_idx      current kernel position
//   busy         high while a tile is in progress
//   done         one-cycle pulse when the tile completes
// Every output comes straight from a flop.
module corelet_seq #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_kij = 9,
  parameter int len_nij = 36,
  parameter int addr_w  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              l0_full,
  input  logic              l0_ready,
  input  logic              ofifo_valid,
  output logic [34:0]       inst,
  output logic              xmem_cen,
  output logic [addr_w-1:0] xmem_addr,
  output logic              pmem_wen,
  output logic [addr_w-1:0] pmem_addr,
  output logic [3:0]        kij_idx,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W  = 16;
  localparam int W_BASE = 1024;

  typedef enum logic [2:0] {
    IDLE, W_LOAD, W_PUSH, A_LOAD, EXEC, DRAIN, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              phase_q, phase_d;
  logic              fin_q, fin_d;
  logic [34:0]       inst_q, inst_d;
  logic              xmem_cen_q, xmem_cen_d;
  logic [addr_w-1:0] xmem_addr_q, xmem_addr_d;
  logic              pmem_wen_q, pmem_wen_d;
  logic [addr_w-1:0] pmem_addr_q, pmem_addr_d;
  logic [3:0]        kij_q, kij_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [addr_w-1:0] load_base;
  logic [CNT_W-1:0]  load_last;

  // Next-state and next-output logic.
  //
  // cnt_q has a different meaning in each state:
  //   W_LOAD / A_LOAD  index of the word being read
  //   W_PUSH / EXEC    L0 reads issued so far
  //   DRAIN            OFIFO reads issued so far
  //
  // phase_q also changes meaning by state:
  //   W_LOAD / A_LOAD  every word has been committed; the last l0_wr
  //                    is on the bus this cycle
  //   W_PUSH           the L0 reads are done; weights are now
  //                    propagating across the columns
  //   DRAIN            every OFIFO read has been issued
  //
  // fin_q marks the cycle that carries the final psum write of a pass.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_cnt_d    = wr_cnt_q;
    phase_d     = phase_q;
    fin_d       = fin_q;
    inst_d      = '0;
    xmem_cen_d  = 1'b1;
    xmem_addr_d = xmem_addr_q;
    pmem_wen_d  = 1'b1;
    pmem_addr_d = pmem_addr_q;
    kij_d       = kij_q;
    done_d      = 1'b0;

    load_base = (state_q == W_LOAD) ? addr_w'(W_BASE + int'(kij_q) * row) : '0;
    load_last = (state_q == W_LOAD) ? CNT_W'(row - 1) : CNT_W'(len_nij - 1);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = W_LOAD;
          kij_d    = '0;
          cnt_d    = '0;
          wr_cnt_d = '0;
          phase_d  = 1'b0;
          fin_d    = 1'b0;
        end
      end

      // SRAM data returns one cycle after the read, so l0_wr follows the
      // read by a cycle. A read that is in flight when L0 reports full
      // has nowhere to land. It is dropped and the same address is read
      // again once L0 has room.
      W_LOAD, A_LOAD: begin
        if (phase_q) begin
          state_d = (state_q == W_LOAD) ? W_PUSH : EXEC;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (!xmem_cen_q) begin
          if (!l0_full) begin
            inst_d[2] = 1'b1;
            if (cnt_q == load_last) begin
              phase_d = 1'b1;
            end else begin
              cnt_d       = cnt_q + CNT_W'(1);
              xmem_cen_d  = 1'b0;
              xmem_addr_d = load_base + addr_w'(cnt_q) + addr_w'(1);
            end
          end
        end else if (!l0_full) begin
          xmem_cen_d  = 1'b0;
          xmem_addr_d = load_base + addr_w'(cnt_q);
        end
      end

      // After the last weight row leaves L0, mac load is held for col more
      // cycles so the weights reach the far columns of the array.
      W_PUSH: begin
        if (!phase_q) begin
          if (l0_ready) begin
            inst_d[3] = 1'b1;
            inst_d[0] = 1'b1;
            if (cnt_q == CNT_W'(row - 1)) begin
              phase_d = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end else begin
          inst_d[0] = 1'b1;
          if (cnt_q == CNT_W'(col - 1)) begin
            state_d = A_LOAD;
            cnt_d   = '0;
            phase_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      EXEC: begin
        if (l0_ready) begin
          inst_d[3] = 1'b1;
          inst_d[1] = 1'b1;
          if (cnt_q == CNT_W'(len_nij - 1)) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      // An OFIFO read in one cycle becomes a psum write in the next.
      // The write address is the running write count.
      DRAIN: begin
        if (fin_q) begin
          cnt_d    = '0;
          wr_cnt_d = '0;
          phase_d  = 1'b0;
          fin_d    = 1'b0;
          if (kij_q == 4'(len_kij - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            kij_d   = kij_q + 4'd1;
            state_d = W_LOAD;
          end
        end else begin
          inst_d[33] = (kij_q != 4'd0);
          if (!phase_q && ofifo_valid) begin
            inst_d[6] = 1'b1;
            if (cnt_q == CNT_W'(len_nij - 1)) begin
              phase_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (inst_q[6]) begin
            pmem_wen_d  = 1'b0;
            pmem_addr_d = addr_w'(wr_cnt_q);
            if (wr_cnt_q == CNT_W'(len_nij - 1)) begin
              fin_d = 1'b1;
            end else begin
              wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // Every piece of sequencer state is held in this one register bank.
  // The asynchronous reset clears all of it, so a reset in the middle
  // of a tile leaves no partial progress behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_cnt_q    <= '0;
      phase_q     <= 1'b0;
      fin_q       <= 1'b0;
      inst_q      <= '0;
      xmem_cen_q  <= 1'b1;
      xmem_addr_q <= '0;
      pmem_wen_q  <= 1'b1;
      pmem_addr_q <= '0;
      kij_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      phase_q     <= phase_d;
      fin_q       <= fin_d;
      inst_q      <= inst_d;
      xmem_cen_q  <= xmem_cen_d;
      xmem_addr_q <= xmem_addr_d;
      pmem_wen_q  <= pmem_wen_d;
      pmem_addr_q <= pmem_addr_d;
      kij_q       <= kij_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign inst      = inst_q;
  assign xmem_cen  = xmem_cen_q;
  assign xmem_addr = xmem_addr_q;
  assign pmem_wen  = pmem_wen_q;
  assign pmem_addr = pmem_addr_q;
  assign kij_idx   = kij_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
